// File: rtl/cripto_pkg.sv
// Shared definitions for the cripto link: word width, decoder FSM states and the
// per-stage key schedule input function (shared with the encryptor).
package cripto_pkg;

    localparam int unsigned WIDTH = 10;

    typedef enum logic [2:0] {
        StIdle,
        StK0,
        StK1,
        StK2,
        StK3,
        StDone
    } state_e;

    // perm10 input for schedule stage 0..3, given the key and the earlier stage outputs.
    function automatic logic [WIDTH-1:0] key_sched_step(
        input logic [1:0]       stage,
        input logic [WIDTH-1:0] key,
        input logic [WIDTH-1:0] k0,
        input logic [WIDTH-1:0] k1,
        input logic [WIDTH-1:0] k2
    );
        case (stage)
            2'd0:    return key;
            2'd1:    return key ^ k0;
            2'd2:    return ~k1 & key;
            default: return k2 ^ (k0 & ~key);
        endcase
    endfunction

endpackage

// File: rtl/cripto_decoder_perm10.sv
// Fixed 10-bit wire permutation used by the key schedule
// (source bit list, 1 = MSB: 3 5 2 7 4 10 1 9 8 6).
module cripto_decoder_perm10 (
    input  logic [9:0] data_i,
    output logic [9:0] data_o
);

    assign data_o = {data_i[7], data_i[5], data_i[8], data_i[3], data_i[6],
                     data_i[0], data_i[9], data_i[1], data_i[2], data_i[4]};

endmodule

// File: rtl/cripto_decoder.sv
// Receive-side decryptor: plaintext = ciphertext ^ fkey(key). The key schedule runs one
// stage per cycle on a single perm10; the last final key is cached for repeated keys.
module cripto_decoder #(
    parameter int unsigned WIDTH    = 10,
    parameter bit          CACHE_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] ciphertext_i,
    input  logic [WIDTH-1:0] key_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] plaintext_o,
    output logic             busy_o,
    output logic             cache_hit_o
);

    import cripto_pkg::*;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ct_q, ct_d, key_q, key_d;
    logic [WIDTH-1:0] k0_q, k0_d, k1_q, k1_d, k2_q, k2_d;
    logic [WIDTH-1:0] pt_q, pt_d;
    logic [WIDTH-1:0] cache_key_q, cache_key_d, cache_fkey_q, cache_fkey_d;
    logic             cache_valid_q, cache_valid_d;
    logic             hit_q, hit_d;

    logic [1:0]       stage;
    logic [WIDTH-1:0] perm_in, perm_out, fkey;
    logic             accept, key_hit;

    always_comb begin
        case (state_q)
            StK1:    stage = 2'd1;
            StK2:    stage = 2'd2;
            StK3:    stage = 2'd3;
            default: stage = 2'd0;
        endcase
    end

    assign perm_in = key_sched_step(stage, key_q, k0_q, k1_q, k2_q);

    cripto_decoder_perm10 u_perm10 (
        .data_i (perm_in),
        .data_o (perm_out)
    );

    // Only meaningful in StK3, where perm_out is k3.
    assign fkey = k0_q ^ k1_q ^ k2_q ^ perm_out;

    // Gated by reset so the upstream never sees ready while the block is held in reset.
    assign in_ready_o  = reset_ni & ((state_q == StIdle) | ((state_q == StDone) & out_ready_i));
    assign accept      = in_valid_i & in_ready_o;
    assign key_hit     = CACHE_EN & cache_valid_q & (key_i == cache_key_q);
    assign out_valid_o = (state_q == StDone);
    assign busy_o      = (state_q == StK0) | (state_q == StK1) | (state_q == StK2) |
                         (state_q == StK3);
    assign plaintext_o = pt_q;
    assign cache_hit_o = hit_q;

    always_comb begin
        state_d       = state_q;
        ct_d          = ct_q;
        key_d         = key_q;
        k0_d          = k0_q;
        k1_d          = k1_q;
        k2_d          = k2_q;
        pt_d          = pt_q;
        cache_key_d   = cache_key_q;
        cache_fkey_d  = cache_fkey_q;
        cache_valid_d = cache_valid_q;
        hit_d         = 1'b0;

        if (accept) begin
            ct_d  = ciphertext_i;
            key_d = key_i;
            if (key_hit) begin
                pt_d    = ciphertext_i ^ cache_fkey_q;
                hit_d   = 1'b1;
                state_d = StDone;
            end else begin
                state_d = StK0;
            end
        end else begin
            case (state_q)
                StK0: begin
                    k0_d    = perm_out;
                    state_d = StK1;
                end
                StK1: begin
                    k1_d    = perm_out;
                    state_d = StK2;
                end
                StK2: begin
                    k2_d    = perm_out;
                    state_d = StK3;
                end
                StK3: begin
                    pt_d          = ct_q ^ fkey;
                    cache_key_d   = key_q;
                    cache_fkey_d  = fkey;
                    cache_valid_d = 1'b1;
                    state_d       = StDone;
                end
                StDone: begin
                    if (out_ready_i) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q       <= StIdle;
            ct_q          <= '0;
            key_q         <= '0;
            k0_q          <= '0;
            k1_q          <= '0;
            k2_q          <= '0;
            pt_q          <= '0;
            cache_key_q   <= '0;
            cache_fkey_q  <= '0;
            cache_valid_q <= 1'b0;
            hit_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            ct_q          <= ct_d;
            key_q         <= key_d;
            k0_q          <= k0_d;
            k1_q          <= k1_d;
            k2_q          <= k2_d;
            pt_q          <= pt_d;
            cache_key_q   <= cache_key_d;
            cache_fkey_q  <= cache_fkey_d;
            cache_valid_q <= cache_valid_d;
            hit_q         <= hit_d;
        end
    end

endmodule

// File: tb/tb_cripto_decoder.sv
// Randomized bench for cripto_decoder: a cycle model built from the key schedule formulas
// plus a round-trip scoreboard, compared against the DUT on every falling edge.
module tb_cripto_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] ct = '0;
    logic [9:0] key = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [9:0] pt;
    logic       busy;
    logic       hit;

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_xfer = 0;
    int n_hits = 0;
    int last_xfer_edge = -1;
    int acc_edge = -1;
    bit checking = 1'b0;
    bit rnd_rdy = 1'b0;
    logic [9:0] sb[$];

    int p10_src [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};

    cripto_decoder #(.WIDTH(10), .CACHE_EN(1'b1)) dut (
        .clk_i        (clk),
        .reset_ni     (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .ciphertext_i (ct),
        .key_i        (key),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .plaintext_o  (pt),
        .busy_o       (busy),
        .cache_hit_o  (hit)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output bit at position j (1 = MSB) takes input bit p10_src[j].
    function automatic logic [9:0] model_perm(input logic [9:0] x);
        logic [9:0] r;
        for (int j = 1; j <= 10; j++) r[10-j] = x[10-p10_src[j-1]];
        return r;
    endfunction

    function automatic logic [9:0] model_fkey(input logic [9:0] k);
        logic [9:0] k0, k1, k2, k3;
        k0 = model_perm(k);
        k1 = model_perm(k ^ k0);
        k2 = model_perm(~k1 & k);
        k3 = model_perm(k2 ^ (k0 & ~k));
        return k0 ^ k1 ^ k2 ^ k3;
    endfunction

    // Behavioural model: a countdown of schedule cycles, a done flag and a one-entry cache.
    int         m_cnt;
    bit         m_done, m_hit, m_cv;
    logic [9:0] m_pt, m_ct, m_key, m_fk, m_ck, m_cf;
    logic       m_ready;

    assign m_ready = rst_n & ((!m_done && m_cnt == 0) || (m_done && out_ready));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0; m_done <= 0; m_hit <= 0; m_cv <= 0;
            m_pt <= '0; m_ct <= '0; m_key <= '0; m_fk <= '0; m_ck <= '0; m_cf <= '0;
        end else begin
            m_hit <= 0;
            if (in_valid && m_ready) begin
                if (m_cv && key == m_ck) begin
                    m_pt <= ct ^ m_cf; m_done <= 1; m_hit <= 1; m_cnt <= 0;
                end else begin
                    m_cnt <= 4; m_done <= 0; m_ct <= ct; m_key <= key; m_fk <= model_fkey(key);
                end
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_done <= 1; m_pt <= m_ct ^ m_fk;
                    m_cv <= 1; m_ck <= m_key; m_cf <= m_fk;
                end
            end else if (m_done && out_ready) begin
                m_done <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("out_valid", 32'(out_valid), 32'(m_done));
            check("busy", 32'(busy), 32'(m_cnt != 0));
            check("in_ready", 32'(in_ready), 32'(m_ready));
            check("cache_hit", 32'(hit), 32'(m_hit));
            check("plaintext", 32'(pt), 32'(m_pt));
            if (hit) n_hits++;
            if (out_valid && out_ready) begin
                n_xfer++;
                last_xfer_edge = cyc + 1;
                if (sb.size() == 0) begin
                    check("unexpected_result", 32'(pt), 32'h0);
                    n_bad++;
                end else begin
                    check("roundtrip", 32'(pt), 32'(sb.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Offer a pair until accepted; returns 1 time unit after the accept edge.
    task automatic send(input logic [9:0] c, input logic [9:0] k, input logic [9:0] exp);
        bit acc;
        int n;
        in_valid = 1'b1; ct = c; key = k;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 60) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end
        if (!acc) check("send_timeout", 32'(n), 32'h0);
        else begin
            sb.push_back(exp);
            acc_edge = cyc;
        end
        in_valid = 1'b0;
        ct = $urandom();
        key = $urandom();
    endtask

    task automatic wait_result(output int lat, output int nbusy);
        lat = 0;
        nbusy = 0;
        while (!out_valid && lat < 20) begin
            if (busy) nbusy++;
            tick();
            lat++;
        end
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 60) begin
            tick();
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'h0);
    endtask

    initial begin
        int lat, nb, h0, x0;
        logic [9:0] p, k, c, held, prev_key;

        // Pin the model with hand-derived values.
        check("model_perm_msb", 32'(model_perm(10'h200)), 32'h008);
        check("model_fkey_zero", 32'(model_fkey(10'h000)), 32'h000);
        check("model_fkey_200", 32'(model_fkey(10'h200)), 32'h048);

        #2 rst_n = 1'b0;
        #1 checking = 1'b1;
        check("reset_in_ready", 32'(in_ready), 32'h0);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_plaintext", 32'(pt), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Cold path with key 0: plaintext equals ciphertext.
        send(10'h2A5, 10'h000, 10'h2A5);
        wait_result(lat, nb);
        check("t1_latency", 32'(lat), 32'd4);
        check("t1_busy_cycles", 32'(nb), 32'd4);
        check("t1_plaintext", 32'(pt), 32'h2A5);
        check("t1_no_hit", 32'(hit), 32'h0);

        // Same key again: served from the cache.
        h0 = n_hits;
        send(10'h0F0, 10'h000, 10'h0F0);
        wait_result(lat, nb);
        check("t2_latency", 32'(lat), 32'd0);
        check("t2_hit", 32'(hit), 32'h1);
        check("t2_plaintext", 32'(pt), 32'h0F0);
        repeat (3) tick();
        check("t2_hit_pulses", 32'(n_hits - h0), 32'd1);

        send(10'h000, 10'h200, 10'h048);
        wait_result(lat, nb);
        check("t2b_plaintext", 32'(pt), 32'h048);

        // Round trip through the encryptor model.
        send(10'h155 ^ model_fkey(10'h3C7), 10'h3C7, 10'h155);
        wait_result(lat, nb);
        check("t3_plaintext", 32'(pt), 32'h155);
        check("t3_latency", 32'(lat), 32'd4);
        drain();

        // Random sweep with random backpressure and occasional repeated keys.
        rnd_rdy = 1'b1;
        prev_key = 10'h3C7;
        for (int i = 0; i < 1000; i++) begin
            p = $urandom();
            k = ($urandom_range(0, 2) == 0) ? prev_key : 10'($urandom());
            prev_key = k;
            send(p ^ model_fkey(k), k, p);
            repeat ($urandom_range(0, 2)) tick();
        end
        rnd_rdy = 1'b0;
        drain();

        // Backpressure in DONE.
        out_ready = 1'b0;
        c = $urandom();
        send(c, 10'h0AB, c ^ model_fkey(10'h0AB));
        wait_result(lat, nb);
        held = pt;
        x0 = n_xfer;
        check("t4_plaintext", 32'(pt), 32'(c ^ model_fkey(10'h0AB)));
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t4_valid_held", 32'(out_valid), 32'h1);
            check("t4_pt_held", 32'(pt), 32'(held));
            check("t4_not_ready", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (3) tick();
        check("t4_one_transfer", 32'(n_xfer - x0), 32'd1);
        check("t4_valid_dropped", 32'(out_valid), 32'h0);
        out_ready = 1'b1;

        // Reset during the K2 stage aborts and clears the cache.
        c = $urandom();
        send(c, 10'h1E3, c ^ model_fkey(10'h1E3));
        repeat (2) tick();
        check("t5_busy_before", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(out_valid), 32'h0);
        check("t5_rst_busy", 32'(busy), 32'h0);
        check("t5_rst_ready", 32'(in_ready), 32'h0);
        check("t5_rst_pt", 32'(pt), 32'h0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_idle_ready", 32'(in_ready), 32'h1);
        send(c, 10'h1E3, c ^ model_fkey(10'h1E3));
        wait_result(lat, nb);
        check("t5_cold_latency", 32'(lat), 32'd4);
        check("t5_no_hit", 32'(hit), 32'h0);
        drain();

        // Back-to-back with alternating keys.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            k = (i % 2 == 0) ? 10'h2D1 : 10'h13E;
            p = $urandom();
            send(p ^ model_fkey(k), k, p);
            if (i > 0) check("t6_no_gap", 32'(acc_edge), 32'(last_xfer_edge));
        end
        drain();

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
